// File: rtl/apb_ws_pkg.sv
// apb_ws_pkg: shared definitions for the wait-state APB slave.
//   - FSM state encoding (legacy-compatible localparam constants)
//   - clog2 helper used to derive the byte-offset width of a bus word
//   - width of the read-latency countdown counter (RD_LATENCY <= 3)
package apb_ws_pkg;

  localparam int CNT_W = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RDWAIT = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  function automatic int clog2(input int value);
    int r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_ws_decode.sv
// apb_ws_decode: combinational address/transfer decode for apb_slave_ws.
//   paddr_i    byte address from the APB master
//   pwrite_i   transfer direction (1 = write)
//   mulbusy_i  multiplier running; blocks writes
//   pstrb_i    byte strobes (present only when APB_STRB_EN is defined)
//   locaddr    register-file word address
//   err        transfer must complete with an error response
module apb_ws_decode
  import apb_ws_pkg::*;
#(
  parameter int BUS_WIDTH      = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int LOC_ADDR_WIDTH = 6
) (
  input  logic [ADDR_WIDTH-1:0]     paddr_i,
  input  logic                      pwrite_i,
  input  logic                      mulbusy_i,
`ifdef APB_STRB_EN
  input  logic [BUS_WIDTH/8-1:0]    pstrb_i,
`endif
  output logic [LOC_ADDR_WIDTH-1:0] locaddr,
  output logic                      err
);

  localparam int ADDR_LSB = clog2(BUS_WIDTH / 8);
  localparam int HI_LSB   = ADDR_LSB + LOC_ADDR_WIDTH;

  // Masks keep the checks legal even when there are no byte-offset bits.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << ADDR_LSB) - 1);
  localparam logic [ADDR_WIDTH-1:0] RANGE_MASK = ~ADDR_WIDTH'((1 << HI_LSB) - 1);

  logic unaligned;
  logic out_of_range;
  logic strb_err;

  assign unaligned    = |(paddr_i & ALIGN_MASK);
  assign out_of_range = |(paddr_i & RANGE_MASK);
  assign locaddr      = paddr_i[ADDR_LSB +: LOC_ADDR_WIDTH];

`ifdef APB_STRB_EN
  // A read carrying byte strobes is malformed.
  assign strb_err = !pwrite_i && (|pstrb_i);
`else
  assign strb_err = 1'b0;
`endif

  assign err = unaligned | out_of_range | (pwrite_i & mulbusy_i) | strb_err;

endmodule

// File: rtl/apb_slave_ws.sv
// apb_slave_ws: APB slave for the matrix-multiplier register file with read
// wait states, decode/alignment errors and write blocking while busy.
// Optional feature macro: APB_STRB_EN (adds pstrb_i / byte-strobed writes).
//   clk_i, rst_i            clock, synchronous active-high reset
//   psel_i .. pwdata_i      APB request side
//   pstrb_i                 APB4 byte strobes (APB_STRB_EN only)
//   prdata_o, pready_o,
//   pslverr_o               APB response side (all registered)
//   reddata_i               register-file read data, valid RD_LATENCY cycles
//                           after the cycle in which doread_o is high
//   mulbusy_i               multiplier running
//   busy_o                  transfer in progress
//   dowrite_o, doread_o     register-file one-cycle enables
//   locaddr_o, writedata_o,
//   wstrb_o                 address/data/strobes captured at the setup cycle
module apb_slave_ws
  import apb_ws_pkg::*;
#(
  parameter int BUS_WIDTH      = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int LOC_ADDR_WIDTH = 6,
  parameter int RD_LATENCY     = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [ADDR_WIDTH-1:0]     paddr_i,
  input  logic [BUS_WIDTH-1:0]      pwdata_i,
`ifdef APB_STRB_EN
  input  logic [BUS_WIDTH/8-1:0]    pstrb_i,
`endif
  output logic [BUS_WIDTH-1:0]      prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  input  logic [BUS_WIDTH-1:0]      reddata_i,
  input  logic                      mulbusy_i,
  output logic                      busy_o,
  output logic                      dowrite_o,
  output logic                      doread_o,
  output logic [LOC_ADDR_WIDTH-1:0] locaddr_o,
  output logic [BUS_WIDTH-1:0]      writedata_o,
  output logic [BUS_WIDTH/8-1:0]    wstrb_o
);

  localparam int SW = BUS_WIDTH / 8;

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [LOC_ADDR_WIDTH-1:0] dec_locaddr;
  logic                      dec_err;
  logic [SW-1:0]             setup_strb;
  logic                      strb_any;
  logic                      setup;

  apb_ws_decode #(
    .BUS_WIDTH      (BUS_WIDTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .LOC_ADDR_WIDTH (LOC_ADDR_WIDTH)
  ) u_decode (
    .paddr_i   (paddr_i),
    .pwrite_i  (pwrite_i),
    .mulbusy_i (mulbusy_i),
`ifdef APB_STRB_EN
    .pstrb_i   (pstrb_i),
`endif
    .locaddr   (dec_locaddr),
    .err       (dec_err)
  );

`ifdef APB_STRB_EN
  assign setup_strb = pstrb_i;
  assign strb_any   = |pstrb_i;
`else
  assign setup_strb = '1;
  assign strb_any   = 1'b1;
`endif

  assign setup = psel_i && !penable_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      prdata_o    <= '0;
      pready_o    <= 1'b0;
      pslverr_o   <= 1'b0;
      busy_o      <= 1'b0;
      dowrite_o   <= 1'b0;
      doread_o    <= 1'b0;
      locaddr_o   <= '0;
      writedata_o <= '0;
      wstrb_o     <= '1;
    end else begin
      // Enables are single-cycle pulses unless re-armed below.
      dowrite_o <= 1'b0;
      doread_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          // penable_i high without a setup cycle is ignored.
          if (setup) begin
            locaddr_o   <= dec_locaddr;
            writedata_o <= pwdata_i;
            wstrb_o     <= setup_strb;
            busy_o      <= 1'b1;
            if (pwrite_i || dec_err) begin
              // Zero-wait completion: pready_o is already high in the first
              // access cycle, which is the DONE cycle of this transfer.
              pready_o  <= 1'b1;
              pslverr_o <= dec_err;
              dowrite_o <= pwrite_i && !dec_err && strb_any;
              state     <= ST_DONE;
            end else begin
              doread_o <= 1'b1;
              cnt      <= CNT_W'(RD_LATENCY);
              state    <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS, ST_RDWAIT: begin
          if (!psel_i) begin
            // Master gave up: drop everything without a response.
            state       <= ST_IDLE;
            cnt         <= '0;
            prdata_o    <= '0;
            busy_o      <= 1'b0;
            locaddr_o   <= '0;
            writedata_o <= '0;
            wstrb_o     <= '1;
          end else if (cnt == '0) begin
            // reddata_i is valid in this cycle; respond in the next.
            prdata_o <= reddata_i;
            pready_o <= 1'b1;
            state    <= ST_DONE;
          end else begin
            cnt   <= cnt - 1'b1;
            state <= ST_RDWAIT;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          pready_o  <= 1'b0;
          pslverr_o <= 1'b0;
          busy_o    <= 1'b0;
          prdata_o  <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_ws.sv
// Bench for apb_slave_ws: three instances (RD_LATENCY 0, 1, 3) share the APB
// stimulus; only the selected instance sees psel. A transfer-level model
// derives per-cycle expected outputs from the protocol rules.
`timescale 1ns/1ps
module tb_apb_slave_ws;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, psel, penable, pwrite, mulbusy;
  logic [15:0] paddr;
  logic [31:0] pwdata, reddata;
  logic [3:0]  pstrb_v;
  int          act;

  logic [31:0] prdata_w    [3];
  logic        pready_w    [3];
  logic        pslverr_w   [3];
  logic        busy_w      [3];
  logic        dowrite_w   [3];
  logic        doread_w    [3];
  logic [5:0]  locaddr_w   [3];
  logic [31:0] writedata_w [3];
  logic [3:0]  wstrb_w     [3];

  logic [31:0] exp_prdata;
  logic        exp_pready, exp_pslverr, exp_busy, exp_dowrite, exp_doread;
  logic [5:0]  exp_loc   [3];
  logic [31:0] exp_wd    [3];
  logic [3:0]  exp_wstrb [3];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_slave_ws #(
      .BUS_WIDTH      (32),
      .ADDR_WIDTH     (16),
      .LOC_ADDR_WIDTH (6),
      .RD_LATENCY     ((g == 2) ? 3 : g)
    ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .psel_i      (psel && (act == g)),
      .penable_i   (penable),
      .pwrite_i    (pwrite),
      .paddr_i     (paddr),
      .pwdata_i    (pwdata),
`ifdef APB_STRB_EN
      .pstrb_i     (pstrb_v),
`endif
      .prdata_o    (prdata_w[g]),
      .pready_o    (pready_w[g]),
      .pslverr_o   (pslverr_w[g]),
      .reddata_i   (reddata),
      .mulbusy_i   (mulbusy),
      .busy_o      (busy_w[g]),
      .dowrite_o   (dowrite_w[g]),
      .doread_o    (doread_w[g]),
      .locaddr_o   (locaddr_w[g]),
      .writedata_o (writedata_w[g]),
      .wstrb_o     (wstrb_w[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s inst=%0d t=%0t: got %h, expected %h", nm, act, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("prdata",    prdata_w[act],           exp_prdata);
      chk("pready",    32'(pready_w[act]),      32'(exp_pready));
      chk("pslverr",   32'(pslverr_w[act]),     32'(exp_pslverr));
      chk("busy",      32'(busy_w[act]),        32'(exp_busy));
      chk("dowrite",   32'(dowrite_w[act]),     32'(exp_dowrite));
      chk("doread",    32'(doread_w[act]),      32'(exp_doread));
      chk("locaddr",   32'(locaddr_w[act]),     32'(exp_loc[act]));
      chk("writedata", writedata_w[act],        exp_wd[act]);
      chk("wstrb",     32'(wstrb_w[act]),       32'(exp_wstrb[act]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    exp_busy    = 1'b0;
    exp_pready  = 1'b0;
    exp_pslverr = 1'b0;
    exp_dowrite = 1'b0;
    exp_doread  = 1'b0;
    exp_prdata  = 32'h0;
  endtask

  task automatic idle(input int n, input bit bad);
    for (int i = 0; i < n; i++) begin
      cyc();
      psel    = bad;
      penable = bad;
      mulbusy = 1'($urandom);
      reddata = $urandom;
      set_idle();
    end
  endtask

  // One APB transfer on instance inst. ab_kind: 0 none, 1 psel drop,
  // 2 reset; applied in access cycle ab_at if that precedes the response.
  task automatic xfer(input int inst, input bit wr, input logic [15:0] addr,
                      input logic [31:0] wd, input bit mb, input logic [31:0] rd,
                      input int ab_kind, input int ab_at, output int n_acc);
    int lat;
    bit err;
    lat   = (inst == 2) ? 3 : inst;
    err   = (addr[1:0] != 2'b00) || (addr[15:8] != 8'h00) || (wr && mb);
    n_acc = (wr || err) ? 1 : 2 + lat;
    cyc();
    act = inst;
    set_idle();
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    mulbusy = mb; reddata = $urandom;
`ifdef APB_STRB_EN
    pstrb_v = wr ? 4'hF : 4'h0;
`else
    pstrb_v = 4'hF;
`endif
    for (int k = 1; k <= n_acc; k++) begin
      cyc();
      penable = 1'b1;
      mulbusy = 1'($urandom);
      reddata = (!wr && !err && k == 1 + lat) ? rd : $urandom;
      if (k == 1) begin
        exp_loc[inst]   = addr[7:2];
        exp_wd[inst]    = wd;
        exp_wstrb[inst] = pstrb_v;
      end
      exp_busy    = 1'b1;
      exp_pready  = (k == n_acc);
      exp_pslverr = (k == n_acc) && err;
      exp_dowrite = (k == 1) && wr && !err;
      exp_doread  = (k == 1) && !wr && !err;
      exp_prdata  = (k == n_acc && !wr && !err) ? rd : 32'h0;
      if (ab_kind != 0 && k == ab_at && k < n_acc) begin
        if (ab_kind == 1) psel = 1'b0;
        else rst = 1'b1;
        cyc();
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        set_idle();
        for (int i = 0; i < 3; i++) begin
          if (ab_kind == 2 || i == inst) begin
            exp_loc[i] = '0; exp_wd[i] = '0; exp_wstrb[i] = 4'hF;
          end
        end
        n_acc = k;
        return;
      end
    end
  endtask

  initial begin
    int n, inst, sel, abk, abt;
    bit wr, mb;
    logic [15:0] a;

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    pwdata = '0; mulbusy = 1'b0; reddata = '0; act = 0; pstrb_v = 4'hF;
    for (int i = 0; i < 3; i++) begin
      exp_loc[i] = '0; exp_wd[i] = '0; exp_wstrb[i] = 4'hF;
    end
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy",   32'(busy_w[i]),   32'h0);
      chk("rst_pready", 32'(pready_w[i]), 32'h0);
      chk("rst_wstrb",  32'(wstrb_w[i]),  32'hF);
      chk("rst_prdata", prdata_w[i],      32'h0);
    end
    rst = 1'b0;

    // Write 0x0008 on RD_LATENCY=1 instance
    xfer(1, 1'b1, 16'h0008, 32'hDEADBEEF, 1'b0, 32'h0, 0, 0, n);
    @(negedge clk);
    chk("tp_wr_dowrite", 32'(dowrite_w[1]), 32'h1);
    chk("tp_wr_locaddr", 32'(locaddr_w[1]), 32'h2);
    chk("tp_wr_wdata",   writedata_w[1],    32'hDEADBEEF);
    chk("tp_wr_pslverr", 32'(pslverr_w[1]), 32'h0);

    // Read 0x000C, response in access cycle 3
    xfer(1, 1'b0, 16'h000C, 32'h0, 1'b0, 32'h12345678, 0, 0, n);
    chk("tp_rd_len", 32'(n), 32'd3);
    @(negedge clk);
    chk("tp_rd_prdata", prdata_w[1],      32'h12345678);
    chk("tp_rd_pready", 32'(pready_w[1]), 32'h1);

    // Write blocked while busy, read of same address allowed (back-to-back)
    xfer(1, 1'b1, 16'h0010, 32'h55AA55AA, 1'b1, 32'h0, 0, 0, n);
    @(negedge clk);
    chk("tp_busy_pslverr", 32'(pslverr_w[1]), 32'h1);
    chk("tp_busy_dowrite", 32'(dowrite_w[1]), 32'h0);
    xfer(1, 1'b0, 16'h0010, 32'h0, 1'b1, 32'hA5A5F00F, 0, 0, n);
    @(negedge clk);
    chk("tp_busyrd_pslverr", 32'(pslverr_w[1]), 32'h0);

    // Unaligned and out-of-range
    xfer(1, 1'b0, 16'h0002, 32'h0, 1'b0, 32'h0, 0, 0, n);
    @(negedge clk);
    chk("tp_unal_pslverr", 32'(pslverr_w[1]), 32'h1);
    xfer(1, 1'b1, 16'h0100, 32'h1, 1'b0, 32'h0, 0, 0, n);
    @(negedge clk);
    chk("tp_oor_pslverr", 32'(pslverr_w[1]), 32'h1);

    // Abort in read access cycle 1, RD_LATENCY=3
    idle(1, 1'b0);
    xfer(2, 1'b0, 16'h0004, 32'h0, 1'b0, 32'h11112222, 1, 1, n);
    @(negedge clk);
    chk("tp_abort_busy", 32'(busy_w[2]), 32'h0);
    idle(6, 1'b0);

    // Reset in RDWAIT, then a normal write
    xfer(2, 1'b0, 16'h0014, 32'h0, 1'b0, 32'hCAFEF00D, 2, 2, n);
    @(negedge clk);
    chk("tp_rst_busy",    32'(busy_w[2]),    32'h0);
    chk("tp_rst_locaddr", 32'(locaddr_w[2]), 32'h0);
    xfer(2, 1'b1, 16'h0018, 32'h0BADBEEF, 1'b0, 32'h0, 0, 0, n);
    @(negedge clk);
    chk("tp_rst_wr_dowrite", 32'(dowrite_w[2]), 32'h1);

    // RD_LATENCY=0: response in access cycle 2; reset during ACCESS
    xfer(0, 1'b0, 16'h0020, 32'h0, 1'b0, 32'h0F0E0D0C, 0, 0, n);
    chk("tp_rd0_len", 32'(n), 32'd2);
    @(negedge clk);
    chk("tp_rd0_prdata", prdata_w[0], 32'h0F0E0D0C);
    xfer(0, 1'b0, 16'h0024, 32'h0, 1'b0, 32'h77778888, 2, 1, n);
    xfer(0, 1'b1, 16'h0028, 32'h9999AAAA, 1'b0, 32'h0, 0, 0, n);
    @(negedge clk);
    chk("tp_rd0_wr_pready", 32'(pready_w[0]), 32'h1);

    // Protocol violation: penable without setup is ignored
    idle(1, 1'b1);
    xfer(0, 1'b1, 16'h002C, 32'h13572468, 1'b0, 32'h0, 0, 0, n);

    // Randomised traffic
    for (int t = 0; t < 250; t++) begin
      inst = $urandom_range(0, 2);
      sel  = $urandom_range(0, 9);
      if (sel < 7)       a = {8'h00, 6'($urandom), 2'b00};
      else if (sel == 7) a = {8'h00, 6'($urandom), 2'($urandom_range(1, 3))};
      else if (sel == 8) a = {8'($urandom_range(1, 255)), 8'($urandom)};
      else               a = 16'($urandom);
      wr  = 1'($urandom);
      mb  = ($urandom_range(0, 3) == 0);
      abk = ($urandom_range(0, 7) == 0) ? 1 : 0;
      abt = $urandom_range(1, 4);
      xfer(inst, wr, a, $urandom, mb, $urandom, abk, abt, n);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2), $urandom_range(0, 4) == 0);
    end
    idle(2, 1'b0);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
